lpc_host_io: RTL and testbench
==============================

Name: lpc_host_io

Overview:
- LPC host-side initiator: issues single-byte LPC I/O read and write cycles, i.e. the transmitter for the bus that the sniffer decodes.
- Takes one request at a time on a valid/ready interface and drives the START, CT/DIR, ADDR and host-TAR phases.
- Samples peripheral SYNC and read data, then returns a one-cycle response.
- Used as bus stimulus and as a minimal host for bring-up against real peripherals and the sniffer.

Parameters:
- SYNC_TIMEOUT, 32: maximum SYNC clocks without a terminal SYNC before the host aborts.
- ABORT_CLOCKS, 4: clocks lpc_frame is held low with AD=1111 during an abort.

Ports:
- lpc_clock  in  1  LPC clock; all logic on the rising edge.
- lpc_reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = I/O write, 0 = I/O read.
- req_addr  in  16  I/O address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-clock response pulse.
- rsp_rdata  out  8  read data; 0 for writes.
- rsp_error  out  1  error SYNC or timeout abort; qualified by rsp_valid.
- lpc_frame  out  1  LFRAME#, low = asserted.
- lpc_ad_out  out  4  AD value driven by the host.
- lpc_ad_oe  out  1  host drives AD when 1.
- lpc_ad_in  in  4  AD as seen on the bus.

Behaviour:
- Reset (lpc_reset=1 at an edge):
  - state IDLE, lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=1111.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - req_ready=0 while lpc_reset is high.
  - Reset mid-cycle abandons the cycle immediately; no response is produced.
- All LPC outputs are registered. A state's values are present for the whole clock it occupies.
- req_ready = (state==IDLE) && !lpc_reset. On accept, req_write, req_addr and req_wdata are latched.
- State sequence:
  - START, 1 clock: frame=0, oe=1, ad=0000.
  - CTDIR, 1 clock: frame=1, ad=0000 for read, 0010 for write.
  - ADDR, 4 clocks: addr[15:12], [11:8], [7:4], [3:0].
  - WDATA, write only, 2 clocks: wdata[3:0], then wdata[7:4].
  - HTAR, 2 clocks: ad=1111 with oe=1 for the first clock, oe=0 for the second.
  - SYNC: oe=0; lpc_ad_in is sampled every clock.
    - 0000: ready; go to RDATA (read) or PTAR (write).
    - 1010: error; set the error flag, then continue exactly as for 0000.
    - Any other value (0101 short wait, 0110 long wait, 1111, other): stay in SYNC and increment the sync counter.
    - If the counter reaches SYNC_TIMEOUT without a terminal SYNC, go to ABORT.
  - RDATA, read only, 2 clocks: capture lpc_ad_in into rdata[3:0], then rdata[7:4].
  - PTAR, 2 clocks: oe=0; the peripheral turns the bus around; lpc_ad_in is ignored.
  - ABORT, ABORT_CLOCKS clocks: frame=0, oe=1, ad=1111. Then 1 clock with frame=1, oe=0, then IDLE with rsp_error=1.
- Response:
  - rsp_valid pulses in the first IDLE clock after PTAR or after abort.
  - rsp_rdata and rsp_error are valid during that clock and hold until the next response.
  - A new request can be accepted in that same clock, so there is a minimum of 1 idle clock between cycles.
- Latency, no wait states: accept at clock 0.
  - Read: START at clock 1, rsp_valid at clock 14.
  - Write: START at clock 1, rsp_valid at clock 14 (WDATA replaces RDATA).
  - Each extra SYNC clock adds 1.
- The sync counter clears on every accept. The timeout boundary is exact: non-terminal values for SYNC_TIMEOUT consecutive SYNC clocks causes an abort; a terminal value on clock SYNC_TIMEOUT (1-based) completes normally.
- req_* inputs are ignored outside acceptance.

Test Plan:
- Read 0x7fe5; peripheral gives SYNC 0000, then AD c, 6 -> ad_out sequence 0000, 0000, 7, f, e, 5, 1111; rsp_valid at clock 14; rsp_rdata=0x6c; rsp_error=0.
- Write 0x0080 / 0xa5 with three 0101 SYNCs before 0000 -> CT 0010, addr 0, 0, 8, 0, data 5, a; rsp_valid at clock 17; rsp_error=0.
- lpc_ad_in held 1111 -> 32 SYNC clocks, 4 ABORT clocks (frame=0, ad=1111), 1 recovery clock, then rsp_valid with rsp_error=1.
- Read with SYNC 1010, then data 3, 2 -> rsp_rdata=0x23, rsp_error=1, normal PTAR timing.
- Back-to-back: req_valid held high with reads of 0x7fe4 and 0x7fe5 -> second START exactly 1 clock after the first rsp_valid; both rdata values correct.
- lpc_reset asserted during the third ADDR clock -> next clock frame=1, oe=0, req_ready low until reset drops, no rsp_valid; a following read completes normally.

Source files
------------

// File: rtl/lpc_host_io.sv
// lpc_host_io: LPC host-side initiator for single-byte I/O read/write cycles.
// Takes one request at a time over valid/ready and drives START, CT/DIR, ADDR,
// optional write data and host turnaround. It then waits for the peripheral
// SYNC, captures read data and returns a one-clock response pulse.
//
// Ports:
//   lpc_clock, lpc_reset      clock (rising edge); synchronous active-high reset
//   req_valid/req_ready       request handshake; req_write/req_addr/req_wdata latched on accept
//   rsp_valid                 one-clock response pulse
//   rsp_rdata, rsp_error      response payload; held until the next response
//   lpc_frame                 LFRAME#, active low
//   lpc_ad_out, lpc_ad_oe     host-driven AD value and its output enable
//   lpc_ad_in                 AD as seen on the bus
module lpc_host_io #(
  parameter int unsigned SYNC_TIMEOUT = 32,
  parameter int unsigned ABORT_CLOCKS = 4
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in
);

  localparam int unsigned CMAX = (SYNC_TIMEOUT > ABORT_CLOCKS) ? SYNC_TIMEOUT : ABORT_CLOCKS;
  // One shared phase counter; must reach at least 3 for the four ADDR nibbles.
  localparam int unsigned CW   = (CMAX > 4) ? $clog2(CMAX) : 2;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CTDIR, S_ADDR, S_WDATA, S_HTAR,
    S_SYNC, S_RDATA, S_PTAR, S_ABORT, S_RECOVER
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          frame_nx, oe_nx, rsp_nx;
  logic [3:0]    ad_nx;
  logic          wr, err;
  logic [15:0]   addr;
  logic [7:0]    wdata, rdata;
  logic          terminal;

  assign req_ready = (state == S_IDLE) && !lpc_reset;
  assign terminal  = (lpc_ad_in == 4'h0) || (lpc_ad_in == 4'hA);

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lpc_frame  <= 1'b1;
      lpc_ad_oe  <= 1'b0;
      lpc_ad_out <= '1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      lpc_frame  <= frame_nx;
      lpc_ad_oe  <= oe_nx;
      lpc_ad_out <= ad_nx;
      rsp_valid  <= rsp_nx;
      if (rsp_nx) begin
        rsp_rdata <= rdata;
        rsp_error <= err || (state == S_RECOVER);
      end
      if (state == S_IDLE && req_valid) begin
        wr    <= req_write;
        addr  <= req_addr;
        wdata <= req_wdata;
        rdata <= '0;
        err   <= 1'b0;
      end
      if (state == S_SYNC && lpc_ad_in == 4'hA) err <= 1'b1;
      if (state == S_RDATA) begin
        if (cnt == '0) rdata[3:0] <= lpc_ad_in;
        else           rdata[7:4] <= lpc_ad_in;
      end
    end
  end

  // Outputs are decoded from the *next* state and counter so that the
  // registered bus values line up exactly with the state they belong to.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    rsp_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (req_valid) state_nx = S_START;
      end
      S_START: begin
        state_nx = S_CTDIR;
        cnt_nx   = '0;
      end
      S_CTDIR: begin
        state_nx = S_ADDR;
        cnt_nx   = '0;
      end
      S_ADDR: if (cnt == CW'(3)) begin
        state_nx = wr ? S_WDATA : S_HTAR;
        cnt_nx   = '0;
      end
      S_WDATA: if (cnt == CW'(1)) begin
        state_nx = S_HTAR;
        cnt_nx   = '0;
      end
      S_HTAR: if (cnt == CW'(1)) begin
        state_nx = S_SYNC;
        cnt_nx   = '0;
      end
      S_SYNC: begin
        if (terminal) begin
          state_nx = wr ? S_PTAR : S_RDATA;
          cnt_nx   = '0;
        end else if (cnt == CW'(SYNC_TIMEOUT - 1)) begin
          state_nx = S_ABORT;
          cnt_nx   = '0;
        end
      end
      S_RDATA: if (cnt == CW'(1)) begin
        state_nx = S_PTAR;
        cnt_nx   = '0;
      end
      S_PTAR: if (cnt == CW'(1)) begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        rsp_nx   = 1'b1;
      end
      S_ABORT: if (cnt == CW'(ABORT_CLOCKS - 1)) begin
        state_nx = S_RECOVER;
        cnt_nx   = '0;
      end
      S_RECOVER: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        rsp_nx   = 1'b1;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase

    frame_nx = 1'b1;
    oe_nx    = 1'b0;
    ad_nx    = 4'hF;
    case (state_nx)
      S_START: begin
        frame_nx = 1'b0;
        oe_nx    = 1'b1;
        ad_nx    = 4'h0;
      end
      S_CTDIR: begin
        oe_nx = 1'b1;
        ad_nx = wr ? 4'h2 : 4'h0;
      end
      S_ADDR: begin
        oe_nx = 1'b1;
        case (cnt_nx[1:0])
          2'd0:    ad_nx = addr[15:12];
          2'd1:    ad_nx = addr[11:8];
          2'd2:    ad_nx = addr[7:4];
          default: ad_nx = addr[3:0];
        endcase
      end
      S_WDATA: begin
        oe_nx = 1'b1;
        ad_nx = (cnt_nx == '0) ? wdata[3:0] : wdata[7:4];
      end
      S_HTAR:  oe_nx = (cnt_nx == '0);
      S_ABORT: begin
        frame_nx = 1'b0;
        oe_nx    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lpc_host_io.sv
module tb_lpc_host_io;

  localparam int T = 32;
  localparam int A = 4;

  logic        clk = 1'b0;
  logic        lpc_reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_error;
  logic [7:0]  rsp_rdata;
  logic        lpc_frame, lpc_ad_oe;
  logic [3:0]  lpc_ad_out, lpc_ad_in;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lpc_host_io #(.SYNC_TIMEOUT(T), .ABORT_CLOCKS(A)) dut (
    .lpc_clock (clk),
    .lpc_reset (lpc_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .lpc_frame (lpc_frame),
    .lpc_ad_out(lpc_ad_out),
    .lpc_ad_oe (lpc_ad_oe),
    .lpc_ad_in (lpc_ad_in)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          waits;   // non-terminal SYNC clocks before the terminal one
    logic [3:0]  wcode;
    logic [3:0]  term;
    logic [7:0]  rd;      // data the peripheral returns on reads
  } txn_t;

  typedef struct {
    txn_t        t;
    int          lat;
    logic [7:0]  rdata;
    bit          err;
    bit          chk_rdata;
  } vec_t;

  typedef struct {
    logic       frame;
    logic       oe;
    logic [3:0] ad;
    bit         chk_ad;
  } bus_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(bit wr, logic [15:0] a, logic [7:0] wd, int waits,
                              logic [3:0] wc, logic [3:0] term, logic [7:0] rd);
    txn_t t;
    t.wr = wr; t.addr = a; t.wd = wd; t.waits = waits;
    t.wcode = wc; t.term = term; t.rd = rd;
    return t;
  endfunction

  function automatic bus_t b(logic f, logic o, logic [3:0] a, bit c);
    bus_t x;
    x.frame = f; x.oe = o; x.ad = a; x.chk_ad = c;
    return x;
  endfunction

  // Response-level reference: latency and payload from the protocol rules.
  function automatic vec_t model(txn_t t);
    vec_t v;
    bit ab = (t.waits >= T);
    v.t = t;
    v.lat = ab ? ((t.wr ? 12 : 10) + T + A) : (14 + t.waits);
    v.err = ab || (t.term == 4'hA);
    v.rdata = t.wr ? 8'h00 : t.rd;
    v.chk_rdata = t.wr || !ab;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input bit preloaded, input bit hold,
                         input bit chain, input txn_t nxt);
    txn_t t = v.t;
    bus_t q[$];
    bit   ab = (t.waits >= T);
    int   s0 = t.wr ? 11 : 9;
    int   c = 0;
    int   guard = 0;
    bit   got = 0;
    int   nsync;

    // Expected per-clock bus picture, clock 1 onwards.
    q.push_back(b(1'b0, 1'b1, 4'h0, 1));
    q.push_back(b(1'b1, 1'b1, t.wr ? 4'h2 : 4'h0, 1));
    q.push_back(b(1'b1, 1'b1, t.addr[15:12], 1));
    q.push_back(b(1'b1, 1'b1, t.addr[11:8], 1));
    q.push_back(b(1'b1, 1'b1, t.addr[7:4], 1));
    q.push_back(b(1'b1, 1'b1, t.addr[3:0], 1));
    if (t.wr) begin
      q.push_back(b(1'b1, 1'b1, t.wd[3:0], 1));
      q.push_back(b(1'b1, 1'b1, t.wd[7:4], 1));
    end
    q.push_back(b(1'b1, 1'b1, 4'hF, 1));
    q.push_back(b(1'b1, 1'b0, 4'hF, 0));
    nsync = ab ? T : t.waits + 1;
    for (int i = 0; i < nsync; i++) q.push_back(b(1'b1, 1'b0, 4'hF, 0));
    if (ab) begin
      for (int i = 0; i < A; i++) q.push_back(b(1'b0, 1'b1, 4'hF, 1));
      q.push_back(b(1'b1, 1'b0, 4'hF, 0));
    end else begin
      if (!t.wr) for (int i = 0; i < 2; i++) q.push_back(b(1'b1, 1'b0, 4'hF, 0));
      for (int i = 0; i < 2; i++) q.push_back(b(1'b1, 1'b0, 4'hF, 0));
    end

    if (!preloaded) begin
      @(negedge clk);
      req_write = t.wr; req_addr = t.addr; req_wdata = t.wd; req_valid = 1'b1;
      while (!req_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("accept_ready", req_ready, 1'b1);
    end

    while (!got && c < v.lat + 20) begin
      @(negedge clk);
      c++;
      if (!hold) begin
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
      end
      if (rsp_valid) got = 1;
      else if (c - 1 < q.size()) begin
        check($sformatf("c%0d_frame", c), lpc_frame, q[c-1].frame);
        check($sformatf("c%0d_oe", c), lpc_ad_oe, q[c-1].oe);
        if (q[c-1].chk_ad) check($sformatf("c%0d_ad", c), lpc_ad_out, q[c-1].ad);
      end
      if (c >= s0 && c < s0 + t.waits)        lpc_ad_in = t.wcode;
      else if (c == s0 + t.waits)             lpc_ad_in = t.term;
      else if (!t.wr && c == s0 + t.waits + 1) lpc_ad_in = t.rd[3:0];
      else if (!t.wr && c == s0 + t.waits + 2) lpc_ad_in = t.rd[7:4];
      else                                    lpc_ad_in = 4'hF;
    end
    lpc_ad_in = 4'hF;
    check("rsp_seen", got, 1'b1);
    check("rsp_latency", c, v.lat);
    check("rsp_latency_trace", c, q.size() + 1);
    check("rsp_error", rsp_error, v.err);
    if (v.chk_rdata) check("rsp_rdata", rsp_rdata, v.rdata);

    if (chain) begin
      req_write = nxt.wr; req_addr = nxt.addr; req_wdata = nxt.wd; req_valid = 1'b1;
      check("b2b_ready", req_ready, 1'b1);
    end else begin
      req_valid = 1'b0;
      @(negedge clk);
      check("rsp_pulse", rsp_valid, 1'b0);
      check("rsp_error_hold", rsp_error, v.err);
      if (v.chk_rdata) check("rsp_rdata_hold", rsp_rdata, v.rdata);
    end
  endtask

  vec_t vecs[8];
  txn_t none;

  initial begin
    none = mk(0, 16'h0, 8'h0, 0, 4'hF, 4'h0, 8'h0);
    vecs[0] = '{mk(0, 16'h7fe5, 8'h00, 0,  4'h5, 4'h0, 8'h6c), 14, 8'h6c, 1'b0, 1'b1};
    vecs[1] = '{mk(1, 16'h0080, 8'ha5, 3,  4'h5, 4'h0, 8'h00), 17, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{mk(0, 16'h1234, 8'h00, 32, 4'hF, 4'h0, 8'h00), 46, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{mk(0, 16'h0060, 8'h00, 0,  4'h5, 4'hA, 8'h23), 14, 8'h23, 1'b1, 1'b1};
    vecs[4] = '{mk(0, 16'h002e, 8'h00, 31, 4'h6, 4'h0, 8'h5a), 45, 8'h5a, 1'b0, 1'b1};
    vecs[5] = '{mk(1, 16'hbeef, 8'h3c, 32, 4'h6, 4'h0, 8'h00), 48, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{mk(1, 16'h0378, 8'h81, 1,  4'hF, 4'hA, 8'h00), 15, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{mk(0, 16'hfffe, 8'h00, 2,  4'h7, 4'h0, 8'hff), 16, 8'hff, 1'b0, 1'b1};

    lpc_reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; lpc_ad_in = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_frame", lpc_frame, 1'b1);
    check("rst_oe", lpc_ad_oe, 1'b0);
    check("rst_ad", lpc_ad_out, 4'hF);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_rsp_error", rsp_error, 1'b0);
    lpc_reset = 1'b0;
    @(negedge clk);
    check("idle_ready", req_ready, 1'b1);

    foreach (vecs[i]) run_txn(vecs[i], 0, 0, 0, none);

    // Back-to-back reads with req_valid held high throughout.
    run_txn(model(mk(0, 16'h7fe4, 8'h00, 0, 4'h5, 4'h0, 8'h11)), 0, 1, 1,
            mk(0, 16'h7fe5, 8'h00, 0, 4'h5, 4'h0, 8'h22));
    run_txn(model(mk(0, 16'h7fe5, 8'h00, 0, 4'h5, 4'h0, 8'h22)), 1, 0, 0, none);

    // Reset during the third ADDR clock abandons the cycle.
    @(negedge clk);
    req_write = 1'b0; req_addr = 16'h7fe5; req_valid = 1'b1;
    check("rstmid_accept", req_ready, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (c == 5) begin
        check("rstmid_addr3_oe", lpc_ad_oe, 1'b1);
        lpc_reset = 1'b1;
      end
    end
    @(negedge clk);
    check("rstmid_frame", lpc_frame, 1'b1);
    check("rstmid_oe", lpc_ad_oe, 1'b0);
    check("rstmid_ready", req_ready, 1'b0);
    check("rstmid_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    check("rstmid_ready2", req_ready, 1'b0);
    lpc_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rstmid_norsp%0d", c), rsp_valid, 1'b0);
      check($sformatf("rstmid_idle_ready%0d", c), req_ready, 1'b1);
    end
    run_txn(vecs[0], 0, 0, 0, none);

    // Randomized transactions against the response-level model.
    for (int i = 0; i < 25; i++) begin
      txn_t t;
      int   r;
      logic [3:0] wc;
      r = $urandom_range(0, 9);
      do wc = 4'($urandom); while (wc == 4'h0 || wc == 4'hA);
      t = mk(1'($urandom), 16'($urandom), 8'($urandom),
             (r < 7) ? r : ((r == 7) ? 31 : ((r == 8) ? 32 : 35)),
             wc, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'hA, 8'($urandom));
      run_txn(model(t), 0, 0, 0, none);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
